// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, ALU and
// mux select codes, condition codes and the condition-evaluation helper.
package arm_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_e;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   // Data-processing cmd field (Funct[4:1]) values that the datapath supports
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [3:0] COND_EQ = 4'd0;
   localparam logic [3:0] COND_NE = 4'd1;
   localparam logic [3:0] COND_CS = 4'd2;
   localparam logic [3:0] COND_CC = 4'd3;
   localparam logic [3:0] COND_MI = 4'd4;
   localparam logic [3:0] COND_PL = 4'd5;
   localparam logic [3:0] COND_VS = 4'd6;
   localparam logic [3:0] COND_VC = 4'd7;
   localparam logic [3:0] COND_HI = 4'd8;
   localparam logic [3:0] COND_LS = 4'd9;
   localparam logic [3:0] COND_GE = 4'd10;
   localparam logic [3:0] COND_LT = 4'd11;
   localparam logic [3:0] COND_GT = 4'd12;
   localparam logic [3:0] COND_LE = 4'd13;
   localparam logic [3:0] COND_AL = 4'd14;
   localparam logic [3:0] COND_NV = 4'd15;

   // flags is {N,Z,C,V}; the never-condition (1111) evaluates false
   function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
      logic n, z, c, v;
      {n, z, c, v} = flags;
      case (cond)
         COND_EQ: cond_holds = z;
         COND_NE: cond_holds = !z;
         COND_CS: cond_holds = c;
         COND_CC: cond_holds = !c;
         COND_MI: cond_holds = n;
         COND_PL: cond_holds = !n;
         COND_VS: cond_holds = v;
         COND_VC: cond_holds = !v;
         COND_HI: cond_holds = c && !z;
         COND_LS: cond_holds = !c || z;
         COND_GE: cond_holds = (n == v);
         COND_LT: cond_holds = (n != v);
         COND_GT: cond_holds = !z && (n == v);
         COND_LE: cond_holds = z || (n != v);
         COND_AL: cond_holds = 1'b1;
         default: cond_holds = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller_cond_logic.sv
// Conditional-execution state: the NZCV register and the per-instruction
// CondEx latch captured in DECODE. Only built when COND_EXEC_EN is defined.
module cond_logic
   import arm_ctrl_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [3:0] cond_i,
   input  logic [3:0] alu_flags_i,
   input  logic       latch_cond_i,
   input  logic       wr_nz_i,
   input  logic       wr_cv_i,
   output logic [3:0] flags_o,
   output logic       cond_ex_o
);

   logic [3:0] flags_q, flags_d;
   logic       cond_ex_q, cond_ex_d;

   always_comb begin
      flags_d   = flags_q;
      cond_ex_d = cond_ex_q;
      if (latch_cond_i) cond_ex_d = cond_holds(cond_i, flags_q);
      if (wr_nz_i)      flags_d[3:2] = alu_flags_i[3:2];
      if (wr_cv_i)      flags_d[1:0] = alu_flags_i[1:0];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         flags_q   <= 4'b0000;
         cond_ex_q <= 1'b0;
      end else begin
         flags_q   <= flags_d;
         cond_ex_q <= cond_ex_d;
      end
   end

   assign flags_o   = flags_q;
   assign cond_ex_o = cond_ex_q;

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle ARM datapath. Condition evaluation
// and the NZCV register are present only when COND_EXEC_EN is defined.
module multicycle_controller
   import arm_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        Reset,
   input  logic [19:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic        AdrSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ALUCtrl,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc,
   output logic [3:0]  State,
   output logic [3:0]  Flags
);

   state_e     state_q, state_d;
   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [3:0] cmd;
   logic       cmd_ok;
   logic [1:0] alu_op;
   logic       cond_ex;
   logic       wb_ok;
   logic       pc_wr, ir_wr, reg_wr, mem_wr;
   logic       unused_rn;

   assign cond  = Instr[19:16];
   assign op    = Instr[15:14];
   assign funct = Instr[13:8];
   assign rd    = Instr[3:0];
   assign cmd   = funct[4:1];
   assign unused_rn = ^Instr[7:4];

   always_comb begin
      cmd_ok = 1'b1;
      alu_op = ALU_ADD;
      case (cmd)
         CMD_ADD: alu_op = ALU_ADD;
         CMD_SUB: alu_op = ALU_SUB;
         CMD_AND: alu_op = ALU_AND;
         CMD_ORR: alu_op = ALU_ORR;
         default: cmd_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!Reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               2'b01:   state_d = S_MEMADR;
               2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR:  state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: state_d = S_MEMWB;
         S_EXECR,
         S_EXECI:   state_d = S_ALUWB;
         default:   state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pc_wr     = 1'b0;
      ir_wr     = 1'b0;
      reg_wr    = 1'b0;
      mem_wr    = 1'b0;
      wb_ok     = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = SRCB_REG;
      ResultSrc = RES_ALUOUT;
      ALUCtrl   = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            ir_wr     = 1'b1;
            pc_wr     = 1'b1;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
         end
         S_MEMADR: ALUSrcB = SRCB_IMM;
         S_MEMREAD: AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            wb_ok     = cond_ex;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            mem_wr = cond_ex;
         end
         S_EXECR: ALUCtrl = alu_op;
         S_EXECI: begin
            ALUSrcB = SRCB_IMM;
            ALUCtrl = alu_op;
         end
         S_ALUWB: wb_ok = cond_ex && cmd_ok;
         S_BRANCH: begin
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALURESULT;
            pc_wr     = cond_ex;
         end
         default: ;
      endcase
      // Writeback to R15 is a PC load rather than a register-file write
      if (wb_ok) begin
         reg_wr = (rd != 4'hF);
         pc_wr  = (rd == 4'hF);
      end
   end

   assign PCWrite  = Reset && pc_wr;
   assign IRWrite  = Reset && ir_wr;
   assign RegWrite = Reset && reg_wr;
   assign MemWrite = Reset && mem_wr;
   assign ImmSrc   = op;
   assign RegSrc   = {op == 2'b01, op == 2'b10};
   assign State    = state_q;

`ifdef COND_EXEC_EN
   logic in_exec;
   logic flag_wr_nz, flag_wr_cv;

   assign in_exec    = (state_q == S_EXECR) || (state_q == S_EXECI);
   assign flag_wr_nz = in_exec && funct[0] && cond_ex && cmd_ok;
   assign flag_wr_cv = flag_wr_nz && ((cmd == CMD_ADD) || (cmd == CMD_SUB));

   cond_logic u_cond_logic (
      .clk_i        (clk),
      .rst_n_i      (Reset),
      .cond_i       (cond),
      .alu_flags_i  (ALUFlags),
      .latch_cond_i (state_q == S_DECODE),
      .wr_nz_i      (flag_wr_nz),
      .wr_cv_i      (flag_wr_cv),
      .flags_o      (Flags),
      .cond_ex_o    (cond_ex)
   );
`else
   logic unused_cond;

   assign cond_ex     = 1'b1;
   assign Flags       = 4'b0000;
   assign unused_cond = ^{ALUFlags, cond};
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction mix plus random
// instructions, each cycle compared against an instruction-level model.
module tb_multicycle_controller;

`ifdef COND_EXEC_EN
   localparam bit COND_EN = 1'b1;
`else
   localparam bit COND_EN = 1'b0;
`endif

   logic        clk;
   logic        Reset;
   logic [19:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
   logic [1:0]  ALUSrcB, ResultSrc, ALUCtrl, ImmSrc, RegSrc;
   logic [3:0]  State, Flags;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] m_flags;
   logic       m_condex;
   logic [23:0] exp_q[$];

   multicycle_controller dut (
      .clk       (clk),
      .Reset     (Reset),
      .Instr     (Instr),
      .ALUFlags  (ALUFlags),
      .PCWrite   (PCWrite),
      .IRWrite   (IRWrite),
      .RegWrite  (RegWrite),
      .MemWrite  (MemWrite),
      .AdrSrc    (AdrSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ResultSrc (ResultSrc),
      .ALUCtrl   (ALUCtrl),
      .ImmSrc    (ImmSrc),
      .RegSrc    (RegSrc),
      .State     (State),
      .Flags     (Flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wire [23:0] obs = {State, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                      ALUSrcB, ResultSrc, ALUCtrl, ImmSrc, RegSrc, Flags};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Returns {supported, alu code} for the data-processing cmd field
   function automatic logic [2:0] dp_op(input logic [3:0] cmd);
      case (cmd)
         4'b0100: return 3'b100;
         4'b0010: return 3'b101;
         4'b0000: return 3'b110;
         4'b1100: return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [23:0] model_out(input int st, input logic [19:0] ins,
                                             input logic cx, input logic [3:0] fl,
                                             input logic rst_n);
      logic pcw, irw, rw, mw, adr, srca;
      logic [1:0] srcb, res, aluc, op;
      logic [2:0] dp;
      logic wb;
      pcw = 0; irw = 0; rw = 0; mw = 0; adr = 0; srca = 0;
      srcb = 0; res = 0; aluc = 0; wb = 0;
      op = ins[15:14];
      dp = dp_op(ins[12:9]);
      case (st)
         0: begin srca = 1; srcb = 2; res = 2; irw = 1; pcw = 1; end
         1: begin srca = 1; srcb = 2; res = 2; end
         2: srcb = 1;
         3: adr = 1;
         4: begin res = 1; wb = cx; end
         5: begin adr = 1; mw = cx; end
         6: aluc = dp[1:0];
         7: begin srcb = 1; aluc = dp[1:0]; end
         8: wb = cx && dp[2];
         9: begin srcb = 1; res = 2; pcw = cx; end
         default: ;
      endcase
      if (wb) begin
         if (ins[3:0] == 4'hF) pcw = 1;
         else rw = 1;
      end
      if (!rst_n) begin pcw = 0; irw = 0; rw = 0; mw = 0; end
      return {st[3:0], pcw, irw, rw, mw, adr, srca, srcb, res, aluc, op,
              op == 2'b01, op == 2'b10, fl};
   endfunction

   // Runs one instruction from FETCH; Reset is pulled low in cycle abort_at
   task automatic run_instr(input logic [31:0] ir, input int abort_at,
                            input logic force_af, input logic [3:0] exec_af);
      logic [19:0] ins;
      int seq[$];
      int st;
      logic rst_n;
      logic [3:0] af;
      logic [2:0] dp;
      ins = ir[31:12];
      dp  = dp_op(ins[12:9]);
      case (ins[15:14])
         2'b01:   seq = ins[8] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
         2'b00:   seq = ins[13] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
         2'b10:   seq = '{0, 1, 9};
         default: seq = '{0, 1};
      endcase
      for (int k = 0; k < seq.size(); k++) begin
         st    = seq[k];
         rst_n = (k != abort_at);
         af    = 4'($urandom_range(0, 15));
         if (force_af && (st == 6 || st == 7)) af = exec_af;
         Instr    = ins;
         ALUFlags = af;
         Reset    = rst_n;
         exp_q.push_back(model_out(st, ins, m_condex, m_flags, rst_n));
         @(negedge clk);
         check($sformatf("ir%h_st%0d", ir, st), {8'h0, obs}, {8'h0, exp_q.pop_front()});
         @(posedge clk);
         #1;
         if (!rst_n) begin
            m_flags  = 4'b0;
            m_condex = !COND_EN;
            break;
         end
         if (st == 1) m_condex = COND_EN ? cond_true(ins[19:16], m_flags) : 1'b1;
         if ((st == 6 || st == 7) && COND_EN && ins[8] && m_condex && dp[2]) begin
            m_flags[3:2] = af[3:2];
            if (dp[1] == 1'b0) m_flags[1:0] = af[1:0];
         end
      end
      Reset = 1'b1;
   endtask

   initial begin
      logic [31:0] ir;
      logic [3:0]  cmds[4];
      int          ab;
      cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100};
      m_flags  = 4'b0;
      m_condex = !COND_EN;
      Reset    = 1'b0;
      Instr    = 20'hE0821;
      ALUFlags = 4'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_hold", {8'h0, obs}, {8'h0, model_out(0, 20'hE0821, 1'b0, 4'b0, 1'b0)});
      @(posedge clk);
      #1;

      run_instr(32'hE0821003, -1, 1'b0, 4'b0);
      run_instr(32'hE0510002, -1, 1'b1, 4'b0100);
      run_instr(32'h0A000002, -1, 1'b0, 4'b0);
      run_instr(32'h1A000002, -1, 1'b0, 4'b0);
      run_instr(32'h10821003, -1, 1'b0, 4'b0);
      run_instr(32'hE5921004, -1, 1'b0, 4'b0);
      run_instr(32'hE5821004, -1, 1'b0, 4'b0);
      run_instr(32'hE0510002, -1, 1'b1, 4'b0110);
      run_instr(32'hE5921004, 4, 1'b0, 4'b0);
      run_instr(32'hE081F003, -1, 1'b0, 4'b0);
      run_instr(32'hEE000000, -1, 1'b0, 4'b0);

      for (int i = 0; i < 400; i++) begin
         ir = $urandom;
         if ($urandom_range(0, 3) != 0) ir[24:21] = cmds[$urandom_range(0, 3)];
         if ($urandom_range(0, 5) == 0) ir[15:12] = 4'hF;
         if ($urandom_range(0, 2) == 0) ir[31:28] = 4'hE;
         ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
         run_instr(ir, ab, 1'b0, 4'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing control unit for the multicycle ARM core. The core shares one ALU and one memory port across the steps of each instruction. This block decodes the instruction register (cond, op, funct, Rd) and steps a Moore FSM through fetch, decode, execute, memory and writeback. It drives every mux select and write enable of the multicycle datapath, and holds the NZCV flags used for conditional execution.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on rising edge
- Reset  input  1  synchronous, active-low; sampled on rising clk
- Instr  input  20  IR bits [31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
- ALUFlags  input  4  {N,Z,C,V} from ALU, current cycle
- PCWrite, IRWrite, RegWrite, MemWrite  output  1 each  write enables
- AdrSrc  output  1  memory address: 0=PC, 1=ALUOut
- ALUSrcA  output  1  0=RD1 reg, 1=PC
- ALUSrcB  output  2  00=RD2 reg, 01=ExtImm, 10=constant 4
- ResultSrc  output  2  00=ALUOut, 01=Data reg, 10=ALUResult
- ALUCtrl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ImmSrc  output  2  equals Op
- RegSrc  output  2  [0]=(Op==10), [1]=(Op==01)
- State  output  4  current FSM state (debug)
- Flags  output  4  registered NZCV

## Operation
- **FETCH**
  - Outputs: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUCtrl=00, ResultSrc=10, IRWrite=1, PCWrite=1.
  - Next: DECODE.
- **DECODE**
  - Outputs: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8 precompute).
  - CondExReg latches CondEx(Instr.Cond, Flags).
  - Next by Op:
    - 01 → MEMADR
    - 00 with Funct[5]=0 → EXECR
    - 00 with Funct[5]=1 → EXECI
    - 10 → BRANCH
    - 11 → FETCH (undefined; no side effects)
- **MEMADR**: ALUSrcA=0, ALUSrcB=01, ALUCtrl=00. Next: MEMREAD if Funct[0]=1, else MEMWRITE.
- **MEMREAD**: AdrSrc=1, ResultSrc=00. Next: MEMWB.
- **MEMWB**
  - ResultSrc=01.
  - If CondExReg and Rd≠15: RegWrite=1.
  - If CondExReg and Rd==15: PCWrite=1, RegWrite=0.
  - Next: FETCH.
- **MEMWRITE**: AdrSrc=1, MemWrite=CondExReg. Next: FETCH.
- **EXECR / EXECI**
  - ALUSrcA=0; ALUSrcB=00 (EXECR) or 01 (EXECI).
  - ALUCtrl from Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - Any other cmd is unsupported: ALUCtrl=00, no writeback, no flag update.
  - Next: ALUWB.
- **ALUWB**: ResultSrc=00. Same RegWrite/PCWrite rule as MEMWB, additionally gated by cmd supported. Next: FETCH.
- **BRANCH**: ALUSrcA=0, ALUSrcB=01, ALUCtrl=00, ResultSrc=10, PCWrite=CondExReg. Next: FETCH.
- Outputs not listed for a state are 0.
- **Flags update** at end of EXECR/EXECI when Funct[0]=1 (S), CondExReg=1 and cmd supported:
  - N,Z update for all four ops.
  - C,V update only for ADD/SUB.
- **CondEx by Cond**:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V
  - GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; 1111 → 0

## Timing
- Instructions take a fixed number of cycles, FETCH included:
  - B: 3
  - data-processing: 4
  - STR: 4
  - LDR: 5
  - undefined: 2
- Condition failure does not shorten an instruction; it only suppresses its writes.
- Outputs are combinational from registered state and Instr. Instr must be stable from DECODE onward; the IR is written only in FETCH.
- Flags written in EXECx are visible to the next instruction's DECODE. The same instruction's gating uses CondExReg, so S-updates never alter its own writeback.
- **During reset** (Reset=0 at an edge):
  - Next state = FETCH, Flags=0000, CondExReg=0.
  - While Reset is low, all four write enables are forced 0 combinationally.
- Reset asserted mid-instruction (any state) aborts it: no write in that cycle, FETCH on the next cycle.
- Reset released: the first cycle is FETCH with IRWrite=PCWrite=1.

## Configuration
- COND_EXEC_EN defined:
  - Full condition evaluation and flags register as above.
- COND_EXEC_EN undefined:
  - The flags register and condition logic are omitted; CondExReg is tied to 1 and all instructions execute.
  - Flags output = 0000; S bit ignored.

## Structure
- **Package arm_ctrl_pkg** holds:
  - state encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9
  - ALUCtrl codes
  - Cond code constants
  - ALUSrcB/ResultSrc select constants
- **Sub-module cond_logic** owns the NZCV register, CondEx evaluation and CondExReg. The whole sub-module is excluded when COND_EXEC_EN is undefined.

## Test plan
- Reset=0 for 2 cycles, Instr=0xE0821003: State=0, all write enables 0, Flags=0000. After release: IRWrite=1, PCWrite=1, then DECODE.
- ADD R1,R2,R3 (0xE0821003): states 0,1,6,8,0. EXECR gives ALUSrcB=00, ALUCtrl=00. ALUWB gives RegWrite=1.
- SUBS R0,R1,R2 (0xE0510002) with ALUFlags=0100 in EXECR → Flags=0100. Then BEQ (0x0A000002): states 0,1,9 with PCWrite=1 in BRANCH.
- With Flags=0100, BNE (0x1A000002): BRANCH PCWrite=0. ADDNE (0x10821003): ALUWB RegWrite=0.
- LDR R1,[R2,#4] (0xE5921004): states 0,1,2,3,4, with AdrSrc=1 in MEMREAD, then ResultSrc=01 and RegWrite=1 in MEMWB. STR (0xE5821004): states 0,1,2,5, with MemWrite=1.
- Reset=0 during MEMWB of LDR: RegWrite=0 that cycle, next State=0, Flags=0000.
